// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with a registered one-hot grant held
// until done, plus a watchdog that revokes grants held for TIMEOUT cycles.
module rr_arbiter8 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_MAX = 8'(TIMEOUT);

  state_t     r_state, w_state_next;
  logic [2:0] r_ptr, w_ptr_next;
  logic [7:0] r_hold_cnt, w_hold_cnt_next;
  logic [7:0] r_gnt, w_gnt_next;
  logic       r_timeout, w_timeout_next;

  logic [2:0] w_idx;
  logic [2:0] w_winner;
  logic [2:0] w_owner;
  logic       w_expired;

  // Scan downward from ptr+7 to ptr so the last hit is the first requester
  // at or after ptr in circular order.
  always_comb begin
    w_idx    = 3'd0;
    w_winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      w_idx = r_ptr + 3'(i);
      if (req[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_owner = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_gnt[i]) begin
        w_owner = 3'(i);
      end
    end
  end

  assign w_expired = (r_hold_cnt == HOLD_MAX);

  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_hold_cnt_next = r_hold_cnt;
    w_gnt_next      = r_gnt;
    w_timeout_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_gnt_next      = 8'd1 << w_winner;
          w_hold_cnt_next = 8'd1;
          w_state_next    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (done || w_expired) begin
          // done takes precedence, so the watchdog pulse only fires without it
          w_gnt_next      = 8'd0;
          w_hold_cnt_next = 8'd0;
          w_ptr_next      = w_owner + 3'd1;
          w_state_next    = ST_IDLE;
          w_timeout_next  = !done;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_gnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 3'd0;
      r_hold_cnt <= 8'd0;
      r_gnt      <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_gnt      <= w_gnt_next;
      r_timeout  <= w_timeout_next;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = |r_gnt;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: stimulus queues expected grants, a
// negedge monitor pops and checks each grant, its length and release.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] g;
    int         len;   // -1: not checked
    logic       to;
    int         gap;   // -1: not checked
  } exp_t;

  exp_t sb_q[$];

  rr_arbiter8 #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1, "global timeout");
  end

  task automatic push(input logic [7:0] g, input int len, input logic to, input int gap);
    exp_t e;
    e.g = g; e.len = len; e.to = to; e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = 8'h00; done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Wait for a grant, then release it with done in cycle len (len 0: let the
  // watchdog revoke it). mid_req is applied in cycle 2, next_req with done.
  task automatic serve(input int len, input logic [7:0] mid_req, input logic [7:0] next_req);
    for (int i = 0; i < 100 && !gnt_valid; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (!gnt_valid) begin
      failures++;
      $display("FAIL serve_wait gnt_valid=%0b required 1 within 100 cycles", gnt_valid);
      return;
    end
    if (len == 0) begin
      for (int i = 0; i < 300 && gnt_valid; i++) begin
        @(posedge clk); #1;
      end
      return;
    end
    for (int k = 0; k < len - 1; k++) begin
      @(posedge clk); #1;
      if (k == 0) req = mid_req;
    end
    done = 1'b1;
    req  = next_req;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  // Monitor: per-cycle invariants plus per-grant scoreboard comparison.
  bit         in_grant = 0;
  exp_t       cur;
  int         cur_len  = 0;
  int         gap      = -1;
  logic [7:0] cur_g    = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_grant = 0;
        gap      = -1;
      end else begin
        checks++;
        if (!$onehot0(gnt) || (gnt_valid != |gnt)) begin
          failures++;
          $display("FAIL invariant gnt=%02h gnt_valid=%0b required onehot0 and valid==|gnt", gnt, gnt_valid);
        end
        if (gnt_valid) begin
          if (!in_grant) begin
            checks++;
            if (sb_q.size() == 0) begin
              failures++;
              $display("FAIL unexpected_grant gnt=%02h required no grant", gnt);
              cur.g = gnt; cur.len = -1; cur.to = 1'b0; cur.gap = -1;
            end else begin
              cur = sb_q.pop_front();
              if (gnt !== cur.g) begin
                failures++;
                $display("FAIL grant_value gnt=%02h required %02h", gnt, cur.g);
              end
            end
            if (cur.gap >= 0) begin
              checks++;
              if (gap != cur.gap) begin
                failures++;
                $display("FAIL idle_gap gap=%0d required %0d", gap, cur.gap);
              end
            end
            in_grant = 1;
            cur_len  = 1;
            cur_g    = gnt;
          end else begin
            cur_len++;
            checks++;
            if (gnt !== cur_g) begin
              failures++;
              $display("FAIL grant_frozen gnt=%02h required %02h", gnt, cur_g);
            end
          end
          checks++;
          if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_during_grant timeout=%0b required 0", timeout);
          end
        end else if (in_grant) begin
          $display("grant gnt=%02h len=%0d timeout=%0b", cur_g, cur_len, timeout);
          if (cur.len >= 0) begin
            checks++;
            if (cur_len != cur.len) begin
              failures++;
              $display("FAIL grant_len len=%0d required %0d", cur_len, cur.len);
            end
          end
          checks++;
          if (timeout !== cur.to) begin
            failures++;
            $display("FAIL release_timeout timeout=%0b required %0b", timeout, cur.to);
          end
          in_grant = 0;
          gap      = 1;
        end else begin
          if (gap >= 0) gap++;
          checks++;
          if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle timeout=%0b required 0", timeout);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    #1;
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_state gnt=%02h valid=%0b timeout=%0b required 00/0/0", gnt, gnt_valid, timeout);
    end

    // No requests for 10 cycles, with stray done pulses in IDLE.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      done = (c % 3 == 1);
      @(posedge clk); #1;
      checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL idle_quiet gnt=%02h valid=%0b timeout=%0b required 00/0/0", gnt, gnt_valid, timeout);
      end
    end
    done = 1'b0;

    // All requesting: 01,02,...,80,01, two cycles each, one idle between.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      logic [7:0] g;
      g = 8'h01 << (i % 8);
      push(g, 2, 1'b0, (i == 0) ? -1 : 1);
    end
    req = 8'hFF;
    for (int i = 0; i < 8; i++) serve(2, 8'hFF, 8'hFF);
    serve(2, 8'hFF, 8'h00);

    // Two requesters alternate; then req[2] drops mid-grant.
    do_reset();
    push(8'h04, 2, 1'b0, -1);
    push(8'h20, 2, 1'b0, 1);
    push(8'h04, 2, 1'b0, 1);
    push(8'h20, 2, 1'b0, 1);
    push(8'h04, 3, 1'b0, 1);
    push(8'h20, 2, 1'b0, 1);
    req = 8'h24;
    for (int i = 0; i < 4; i++) serve(2, 8'h24, 8'h24);
    serve(3, 8'h20, 8'h20);
    serve(2, 8'h20, 8'h00);

    // Owner never completes: watchdog revokes after 16 cycles, then re-grant.
    do_reset();
    push(8'h08, 16, 1'b1, -1);
    push(8'h08, 2, 1'b0, 1);
    req = 8'h08;
    serve(0, 8'h08, 8'h08);
    serve(2, 8'h08, 8'h00);

    // done on the 16th held cycle beats expiry; ptr advances to 4.
    do_reset();
    push(8'h08, 16, 1'b0, -1);
    push(8'h10, 2, 1'b0, 1);
    req = 8'h08;
    serve(16, 8'h08, 8'hFF);
    serve(2, 8'hFF, 8'h00);

    // Asynchronous reset in the middle of a grant of 10.
    do_reset();
    push(8'h10, -1, 1'b0, -1);
    req = 8'h10;
    for (int i = 0; i < 20 && !gnt_valid; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #2;
    checks++;
    if (gnt !== 8'h10) begin
      failures++;
      $display("FAIL pre_reset_grant gnt=%02h required 10", gnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL async_reset gnt=%02h valid=%0b timeout=%0b required 00/0/0", gnt, gnt_valid, timeout);
    end
    req = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    push(8'h01, 2, 1'b0, -1);
    rst = 1'b0;
    req = 8'hFF;
    serve(2, 8'hFF, 8'h00);

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Eight-requester round-robin arbiter that issues a registered one-hot grant vector, held until the owner signals completion.
- Sits directly upstream of the team's 8:3 one-hot encoder, which converts the grant into a 3-bit owner index.
- Guarantees the grant bus is only ever all-zero or exactly one-hot, so the combinational encoder never sees an undefined pattern.
- A watchdog revokes grants whose owner never completes.

Parameters:
- TIMEOUT, 16: maximum cycles a grant may be held. Legal range 2..255. Counter width is 8 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i is requester i. Level-sensitive.
- done  input  1  owner completion pulse. Sampled only in GRANT.
- gnt  output  8  registered grant. Either 8'b0 or exactly one bit set.
- gnt_valid  output  1  high whenever gnt is non-zero.
- timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Reset (async assert, any time including mid-grant): gnt=8'b0, gnt_valid=0, timeout=0, ptr=3'd0, hold_cnt=0, state=IDLE. Release is synchronous to clk.
- Internal state:
  - ptr[2:0]: highest-priority requester index.
  - hold_cnt[7:0]: cycles the current grant has been held.
  - FSM with states IDLE and GRANT.
- IDLE:
  - If req==0: stay in IDLE; outputs remain 0.
  - Else: winner = first set bit of req scanning ptr, ptr+1, ..., wrapping modulo 8.
  - At the next edge: gnt = one-hot(winner), gnt_valid=1, hold_cnt=1, state=GRANT.
  - Latency: req visible before edge k gives gnt asserted after edge k (one cycle).
- GRANT:
  - gnt is frozen. Changes on req, including the owner dropping its request, are ignored.
  - If done=1: at the next edge gnt=0, gnt_valid=0, ptr = owner index + 1 (mod 8, so 7 wraps to 0), state=IDLE.
  - Else if hold_cnt==TIMEOUT: same as done, and additionally timeout=1 for that one cycle.
  - Else: hold_cnt increments.
  - A grant is therefore visible for at most TIMEOUT cycles.
- Done and watchdog expiry on the same cycle: done wins, timeout stays 0.
- Fairness:
  - After every grant release there is exactly one IDLE cycle (bus turnaround). Back-to-back grants are therefore spaced by at least one zero cycle on gnt.
  - With all 8 requesting continuously and done returned each grant, the grant order is 0,1,...,7,0,...
- done while in IDLE is ignored. It does not modify ptr.
- ptr changes only on grant release, never on arbitration.
- timeout is 0 on every cycle other than the single revoke cycle.
- Invariant (assert in bench every cycle): $onehot0(gnt) and gnt_valid == |gnt.

Test Plan:
- Reset then req=8'b0000_0000 for 10 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
- Reset, req=8'hFF held, done pulsed on the 2nd cycle of every grant -> gnt sequence 01,00,02,00,04,00,...,80,00,01; each grant held 2 cycles.
- Reset, req=8'b0010_0100, done each grant -> grants alternate 04,20,04,20. Then drop req[2] mid-grant of 04 -> grant 04 stays until done, next grant 20.
- Reset, req=8'h08, done never asserted, TIMEOUT=16 -> gnt=08 for 16 cycles, timeout=1 on the release edge, then IDLE one cycle, then 08 re-granted (ptr=4 wraps around to 3).
- done and expiry on the same cycle (done on the 16th held cycle) -> grant released, timeout stays 0, ptr advances.
- Assert rst mid-grant (gnt=10) -> gnt, gnt_valid and timeout go 0 immediately without a clock. After release with req=8'hFF, first grant is 01 (ptr reset to 0).
